// File: rtl/monopix2_ro_pkg.sv
// Shared definitions for the Monopix2 token/serial readout path.
// Hit word layout, field positions, FSM states and packing helper.
package monopix2_ro_pkg;

  localparam int COL_WIDTH  = 6;
  localparam int ROW_WIDTH  = 9;
  localparam int TS_WIDTH   = 6;
  localparam int WORD_WIDTH = COL_WIDTH + ROW_WIDTH + 2 * TS_WIDTH;

  localparam int TE_LSB  = 0;
  localparam int LE_LSB  = TS_WIDTH;
  localparam int ROW_LSB = 2 * TS_WIDTH;
  localparam int COL_LSB = 2 * TS_WIDTH + ROW_WIDTH;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  function automatic logic [WORD_WIDTH-1:0] pack(
    input logic [COL_WIDTH-1:0] col,
    input logic [ROW_WIDTH-1:0] row,
    input logic [TS_WIDTH-1:0]  le,
    input logic [TS_WIDTH-1:0]  te
  );
    return {col, row, le, te};
  endfunction

endpackage

// File: rtl/mono_hit_fifo.sv
// Synchronous hit FIFO with occupancy count.
// Pointers wrap modulo DEPTH; push when full and pop when empty are dropped.
module mono_hit_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 27
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [W-1:0]               wdata_i,
  output logic [W-1:0]               rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mono_data_tx.sv
// Chip-side Monopix2 readout transmitter: buffers hits, raises TokOut,
// and shifts one word MSB-first per Read rising edge under Freeze.
module mono_data_tx
  import monopix2_ro_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int COL_W = COL_WIDTH,
  parameter int ROW_W = ROW_WIDTH,
  parameter int TS_W  = TS_WIDTH
) (
  input  logic                       ClkOut,
  input  logic                       nRst,
  input  logic                       HIT_VALID,
  output logic                       HIT_READY,
  input  logic [COL_W-1:0]           HIT_COL,
  input  logic [ROW_W-1:0]           HIT_ROW,
  input  logic [TS_W-1:0]            HIT_LE,
  input  logic [TS_W-1:0]            HIT_TE,
  input  logic                       Freeze,
  input  logic                       Read,
  output logic                       TokOut,
  output logic                       DataOut,
  output logic                       BUSY,
  output logic                       RD_ERR,
  output logic [$clog2(DEPTH+1)-1:0] FIFO_COUNT
);

  localparam int WW = COL_W + ROW_W + 2 * TS_W;
  localparam int BW = $clog2(WW);
  localparam logic [BW-1:0] LAST = BW'(WW - 1);

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          req;
  logic [WW-1:0] head;

  state_e        state_q, state_d;
  logic [WW-1:0] sreg_q, sreg_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          err_q, err_d;
  logic          read_q;
  logic          tok_q;
  logic          dout_q;
  logic          busy_q;

  assign HIT_READY = ~full & ~Freeze;
  assign push      = HIT_VALID & HIT_READY;
  assign req       = Read & ~read_q;

  mono_hit_fifo #(
    .DEPTH (DEPTH),
    .W     (WW)
  ) u_fifo (
    .clk_i   (ClkOut),
    .rst_ni  (nRst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({HIT_COL, HIT_ROW, HIT_LE, HIT_TE}),
    .rdata_o (head),
    .count_o (FIFO_COUNT),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    bcnt_d  = bcnt_q;
    pop     = 1'b0;
    err_d   = err_q
            | (req & ((state_q == SHIFT) | empty | ~Freeze));
    case (state_q)
      IDLE: begin
        if (req & Freeze & ~empty) begin
          pop     = 1'b1;
          sreg_d  = head;
          bcnt_d  = LAST;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sreg_d = {sreg_q[WW-2:0], 1'b0};
        bcnt_d = bcnt_q - 1'b1;
        if (bcnt_q == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered so the host can sample them on the falling edge.
  always_ff @(posedge ClkOut) begin
    if (!nRst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      bcnt_q  <= '0;
      err_q   <= 1'b0;
      read_q  <= 1'b0;
      tok_q   <= 1'b0;
      dout_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      bcnt_q  <= bcnt_d;
      err_q   <= err_d;
      read_q  <= Read;
      tok_q   <= (FIFO_COUNT != '0);
      dout_q  <= (state_q == SHIFT) & sreg_q[WW-1];
      busy_q  <= (state_q == SHIFT);
    end
  end

  assign TokOut  = tok_q;
  assign DataOut = dout_q;
  assign BUSY    = busy_q;
  assign RD_ERR  = err_q;

endmodule

// File: tb/tb_mono_data_tx.sv
// Directed self-checking bench for mono_data_tx.
// Drives hits and host reads, checks serial words and flags.
module tb_mono_data_tx;

  logic        ClkOut = 1'b0;
  logic        nRst;
  logic        HIT_VALID;
  logic        HIT_READY;
  logic [5:0]  HIT_COL;
  logic [8:0]  HIT_ROW;
  logic [5:0]  HIT_LE;
  logic [5:0]  HIT_TE;
  logic        Freeze;
  logic        Read;
  logic        TokOut;
  logic        DataOut;
  logic        BUSY;
  logic        RD_ERR;
  logic [4:0]  FIFO_COUNT;

  int tests = 0;
  int fails = 0;
  logic [26:0] w;

  always #5 ClkOut = ~ClkOut;

  mono_data_tx #(
    .DEPTH (16),
    .COL_W (6),
    .ROW_W (9),
    .TS_W  (6)
  ) dut (
    .ClkOut     (ClkOut),
    .nRst       (nRst),
    .HIT_VALID  (HIT_VALID),
    .HIT_READY  (HIT_READY),
    .HIT_COL    (HIT_COL),
    .HIT_ROW    (HIT_ROW),
    .HIT_LE     (HIT_LE),
    .HIT_TE     (HIT_TE),
    .Freeze     (Freeze),
    .Read       (Read),
    .TokOut     (TokOut),
    .DataOut    (DataOut),
    .BUSY       (BUSY),
    .RD_ERR     (RD_ERR),
    .FIFO_COUNT (FIFO_COUNT)
  );

  function automatic logic [26:0] mk(input int i);
    return {6'(i), 9'(i * 37 + 5), 6'(i + 9), 6'(63 - i)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ClkOut);
    #1;
  endtask

  task automatic push_hit(input logic [26:0] word);
    {HIT_COL, HIT_ROW, HIT_LE, HIT_TE} = word;
    HIT_VALID = 1'b1;
    tick();
    HIT_VALID = 1'b0;
  endtask

  task automatic pulse_read();
    Read = 1'b1;
    tick();
    Read = 1'b0;
    tick();
  endtask

  // Request at edge t; bit k sampled after edge t+27-k.
  task automatic read_word(input int mid, output logic [26:0] word);
    word = '0;
    Read = 1'b1;
    tick();
    for (int k = 26; k >= 0; k--) begin
      Read = (k == mid);
      tick();
      word[k] = DataOut;
      if (k == 26) chk("busy_first", 32'(BUSY), 32'd1);
    end
    Read = 1'b0;
    tick();
    chk("dout_idle", 32'(DataOut), 32'd0);
    chk("busy_idle", 32'(BUSY), 32'd0);
  endtask

  initial begin
    nRst = 1'b0;
    HIT_VALID = 1'b0;
    HIT_COL = '0;
    HIT_ROW = '0;
    HIT_LE = '0;
    HIT_TE = '0;
    Freeze = 1'b0;
    Read = 1'b0;
    tick();
    tick();
    chk("rst_tok", 32'(TokOut), 32'd0);
    chk("rst_dout", 32'(DataOut), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_err", 32'(RD_ERR), 32'd0);
    chk("rst_cnt", 32'(FIFO_COUNT), 32'd0);
    chk("rst_rdy", 32'(HIT_READY), 32'd1);
    nRst = 1'b1;
    tick();

    push_hit({6'h2A, 9'h155, 6'h11, 6'h3C});
    chk("a_cnt", 32'(FIFO_COUNT), 32'd1);
    tick();
    chk("a_tok_up", 32'(TokOut), 32'd1);
    Freeze = 1'b1;
    read_word(-1, w);
    chk("a_word", 32'(w), 32'h555547C);
    chk("a_tok_dn", 32'(TokOut), 32'd0);
    chk("a_err", 32'(RD_ERR), 32'd0);
    chk("a_cnt0", 32'(FIFO_COUNT), 32'd0);

    {HIT_COL, HIT_ROW, HIT_LE, HIT_TE} = mk(40);
    HIT_VALID = 1'b1;
    #1;
    chk("frz_rdy", 32'(HIT_READY), 32'd0);
    tick();
    chk("frz_cnt", 32'(FIFO_COUNT), 32'd0);
    Freeze = 1'b0;
    #1;
    chk("rel_rdy", 32'(HIT_READY), 32'd1);
    tick();
    HIT_VALID = 1'b0;
    chk("rel_cnt", 32'(FIFO_COUNT), 32'd1);
    Freeze = 1'b1;
    read_word(-1, w);
    chk("rel_word", 32'(w), 32'(mk(40)));

    Freeze = 1'b0;
    HIT_VALID = 1'b1;
    for (int i = 0; i < 16; i++) begin
      {HIT_COL, HIT_ROW, HIT_LE, HIT_TE} = mk(i);
      tick();
    end
    chk("full_cnt", 32'(FIFO_COUNT), 32'd16);
    chk("full_rdy", 32'(HIT_READY), 32'd0);
    {HIT_COL, HIT_ROW, HIT_LE, HIT_TE} = mk(16);
    tick();
    chk("full_hold", 32'(FIFO_COUNT), 32'd16);
    HIT_VALID = 1'b0;
    Freeze = 1'b1;
    for (int i = 0; i < 16; i++) begin
      read_word(-1, w);
      chk("full_word", 32'(w), 32'(mk(i)));
    end
    chk("full_tok", 32'(TokOut), 32'd0);
    chk("full_cnt0", 32'(FIFO_COUNT), 32'd0);
    chk("full_err", 32'(RD_ERR), 32'd0);

    pulse_read();
    chk("e_empty", 32'(RD_ERR), 32'd1);
    chk("e_empty_cnt", 32'(FIFO_COUNT), 32'd0);
    Freeze = 1'b0;
    push_hit(mk(50));
    push_hit(mk(51));
    pulse_read();
    chk("e_nofrz_cnt", 32'(FIFO_COUNT), 32'd2);
    chk("e_nofrz", 32'(RD_ERR), 32'd1);
    Freeze = 1'b1;
    tick();
    read_word(16, w);
    chk("e_mid_word", 32'(w), 32'(mk(50)));
    chk("e_mid_cnt", 32'(FIFO_COUNT), 32'd1);
    read_word(-1, w);
    chk("e_next_word", 32'(w), 32'(mk(51)));
    chk("e_sticky", 32'(RD_ERR), 32'd1);
    nRst = 1'b0;
    tick();
    nRst = 1'b1;
    chk("e_clr", 32'(RD_ERR), 32'd0);

    Freeze = 1'b0;
    push_hit(mk(60));
    push_hit(mk(61));
    tick();
    Freeze = 1'b1;
    Read = 1'b1;
    tick();
    Read = 1'b0;
    repeat (17) tick();
    chk("ab_busy_pre", 32'(BUSY), 32'd1);
    nRst = 1'b0;
    tick();
    chk("ab_dout", 32'(DataOut), 32'd0);
    chk("ab_busy", 32'(BUSY), 32'd0);
    chk("ab_tok", 32'(TokOut), 32'd0);
    chk("ab_cnt", 32'(FIFO_COUNT), 32'd0);
    nRst = 1'b1;
    Freeze = 1'b0;
    tick();

    begin
      int n;
      int cnt;
      n = 70;
      for (int c = 0; c < 3; c++) begin
        cnt = (c == 2) ? 6 : 7;
        Freeze = 1'b0;
        for (int j = 0; j < cnt; j++) push_hit(mk(n + j));
        chk("wr_fill", 32'(FIFO_COUNT), 32'(cnt));
        Freeze = 1'b1;
        for (int j = 0; j < cnt; j++) begin
          read_word(-1, w);
          chk("wr_word", 32'(w), 32'(mk(n + j)));
          chk("wr_cnt", 32'(FIFO_COUNT), 32'(cnt - 1 - j));
        end
        n += cnt;
      end
    end
    chk("wr_err", 32'(RD_ERR), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
